// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared types and helpers for the SIPO frame capture stage
package sipo_pkg;

  typedef enum logic {IDLE, SHIFT} sipo_state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// rtl/sipo_out_buf.sv - one-entry valid/ready output register for captured words
module sipo_out_buf
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             dropped
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    dropped = 1'b0;
    if (push) begin
      // A pop on the completion edge frees the slot for the new word.
      if (!valid_q || pop_ready) begin
        data_d  = push_data;
        valid_d = 1'b1;
      end else begin
        dropped = 1'b1;
      end
    end else if (valid_q && pop_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/sipo_frame_capture.sv
// rtl/sipo_frame_capture.sv - serial-in/parallel-out word capture with frame and overrun flags
module sipo_frame_capture
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err,
  input  logic             err_clr
);

  localparam int             CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  sipo_state_t      state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;
  logic             push, ferr_set, dropped;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr, input logic b);
    if (MSB_FIRST) return {sr[WIDTH-2:0], b};
    else           return {b, sr[WIDTH-1:1]};
  endfunction

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    if (din_valid) begin
      case (state_q)
        IDLE: if (frame) begin
          sr_d    = shift_in('0, din);
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
        SHIFT: if (frame) begin
          // A new frame mid-word aborts the partial and restarts on this bit.
          ferr_set = 1'b1;
          sr_d     = shift_in('0, din);
          cnt_d    = CW'(1);
        end else begin
          sr_d = shift_in(sr_q, din);
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
            push    = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    overrun_d   = err_clr ? 1'b0 : (overrun_q | dropped);
    frame_err_d = err_clr ? 1'b0 : (frame_err_q | ferr_set);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  sipo_out_buf #(.WIDTH(WIDTH)) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (sr_d),
    .pop_ready (pout_ready),
    .data      (pout),
    .valid     (pout_valid),
    .dropped   (dropped)
  );

  assign busy      = (state_q == SHIFT);
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sipo_frame_capture.sv
// tb/tb_sipo_frame_capture.sv - self-checking bench for sipo_frame_capture (both bit orders)
module tb_sipo_frame_capture;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b0, din_valid = 1'b0, frame = 1'b0, pout_ready = 1'b0, err_clr = 1'b0;
  logic [W-1:0] pout_m, pout_l;
  logic pv_m, pv_l, busy_m, busy_l, ov_m, ov_l, fe_m, fe_l;

  int errors = 0;
  int checks = 0;

  int           q[$];
  logic [W-1:0] m_pout, m_pout_l;
  logic         m_valid, m_over, m_ferr;

  always #5 clk = ~clk;

  sipo_frame_capture #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame(frame),
    .pout(pout_m), .pout_valid(pv_m), .pout_ready(pout_ready), .busy(busy_m),
    .overrun(ov_m), .frame_err(fe_m), .err_clr(err_clr));

  sipo_frame_capture #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame(frame),
    .pout(pout_l), .pout_valid(pv_l), .pout_ready(pout_ready), .busy(busy_l),
    .overrun(ov_l), .frame_err(fe_l), .err_clr(err_clr));

  task automatic model_reset();
    q.delete();
    m_pout = '0; m_pout_l = '0; m_valid = 1'b0; m_over = 1'b0; m_ferr = 1'b0;
  endtask

  // Reference: collect bits of the current word in a queue, pack when WIDTH have arrived.
  task automatic model_edge();
    bit done, drop, fset;
    int wm, wl;
    done = 0; drop = 0; fset = 0; wm = 0; wl = 0;
    if (!rst) return;
    if (din_valid) begin
      if (frame) begin
        if (q.size() > 0) fset = 1;
        q.delete();
        q.push_back(int'(din));
      end else if (q.size() > 0) begin
        q.push_back(int'(din));
        if (q.size() == W) begin
          done = 1;
          for (int i = 0; i < W; i++) begin
            wm = wm * 2 + q[i];
            wl = wl + q[i] * (1 << i);
          end
          q.delete();
        end
      end
    end
    if (done) begin
      if (!m_valid || pout_ready) begin
        m_pout = W'(wm); m_pout_l = W'(wl); m_valid = 1'b1;
      end else drop = 1;
    end else if (m_valid && pout_ready) m_valid = 1'b0;
    m_over = err_clr ? 1'b0 : (m_over | drop);
    m_ferr = err_clr ? 1'b0 : (m_ferr | fset);
  endtask

  task automatic step(input logic d, input logic dv, input logic fr, input logic rdy, input logic clr);
    din = d; din_valid = dv; frame = fr; pout_ready = rdy; err_clr = clr;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] v, input logic rdy, input logic rdy_last);
    for (int i = 0; i < W; i++)
      step(v[W-1-i], 1'b1, (i == 0), (i == W-1) ? rdy_last : rdy, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    #12;
    checks++;
    if ({pout_m, pv_m, busy_m, ov_m, fe_m, pout_l, pv_l} !== '0) begin
      errors++;
      $display("FAIL reset_state: got pout=%h v=%b busy=%b ov=%b fe=%b pout_l=%h v_l=%b, want all 0",
               pout_m, pv_m, busy_m, ov_m, fe_m, pout_l, pv_l);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_single();
    for (int i = 0; i < W; i++) begin
      step(4'b1011 >> (W-1-i), 1'b1, (i == 0), 1'b1, 1'b0);
      if (i < W-1) begin
        checks++;
        if (busy_m !== 1'b1) begin errors++; $display("FAIL single_busy beat %0d: got %b want 1", i, busy_m); end
      end
    end
    checks++;
    if (pout_m !== 4'hB || pv_m !== 1'b1 || busy_m !== 1'b0) begin
      errors++; $display("FAIL single_word: got pout=%h v=%b busy=%b want B 1 0", pout_m, pv_m, busy_m);
    end
    checks++;
    if (pout_l !== 4'b1101 || pv_l !== 1'b1) begin
      errors++; $display("FAIL single_lsb_first: got pout=%b v=%b want 1101 1", pout_l, pv_l);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (pv_m !== 1'b0 || pout_m !== 4'hB) begin
      errors++; $display("FAIL single_pop: got v=%b pout=%h want 0 B", pv_m, pout_m);
    end
  endtask

  task automatic test_gaps();
    logic [W-1:0] v;
    v = 4'hB;
    for (int i = 0; i < W; i++) begin
      step(v[W-1-i], 1'b1, (i == 0), 1'b1, 1'b0);
      if (i < W-1) begin
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      end
    end
    checks++;
    if (pout_m !== 4'hB || pv_m !== 1'b1 || ov_m !== 1'b0 || fe_m !== 1'b0) begin
      errors++; $display("FAIL gaps_word: got pout=%h v=%b ov=%b fe=%b want B 1 0 0", pout_m, pv_m, ov_m, fe_m);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    send_word(4'hA, 1'b0, 1'b0);
    send_word(4'h5, 1'b0, 1'b0);
    checks++;
    if (pout_m !== 4'hA || pv_m !== 1'b1 || ov_m !== 1'b1) begin
      errors++; $display("FAIL b2b_overrun: got pout=%h v=%b ov=%b want A 1 1", pout_m, pv_m, ov_m);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (pv_m !== 1'b0 || pout_m !== 4'hA || ov_m !== 1'b1) begin
      errors++; $display("FAIL b2b_pop: got v=%b pout=%h ov=%b want 0 A 1", pv_m, pout_m, ov_m);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ov_m !== 1'b0) begin errors++; $display("FAIL b2b_clear: got ov=%b want 0", ov_m); end
  endtask

  task automatic test_simul_pop();
    send_word(4'hA, 1'b0, 1'b0);
    send_word(4'h5, 1'b0, 1'b1);
    checks++;
    if (pout_m !== 4'h5 || pv_m !== 1'b1 || ov_m !== 1'b0) begin
      errors++; $display("FAIL simul_pop: got pout=%h v=%b ov=%b want 5 1 0", pout_m, pv_m, ov_m);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_frame_err();
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (fe_m !== 1'b1 || pv_m !== 1'b0) begin
      errors++; $display("FAIL frame_err_set: got fe=%b v=%b want 1 0", fe_m, pv_m);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pout_m !== 4'b0011 || pv_m !== 1'b1 || ov_m !== 1'b0 || fe_m !== 1'b1) begin
      errors++; $display("FAIL frame_err_word: got pout=%b v=%b ov=%b fe=%b want 0011 1 0 1", pout_m, pv_m, ov_m, fe_m);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (fe_m !== 1'b0 || pv_m !== 1'b0) begin
      errors++; $display("FAIL frame_err_clear: got fe=%b v=%b want 0 0", fe_m, pv_m);
    end
  endtask

  task automatic test_reset_mid();
    send_word(4'hA, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({pout_m, pv_m, busy_m, ov_m, fe_m, pout_l, pv_l, busy_l} !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: got pout=%h v=%b busy=%b ov=%b fe=%b pout_l=%h, want all 0",
               pout_m, pv_m, busy_m, ov_m, fe_m, pout_l);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    send_word(4'h6, 1'b0, 1'b0);
    checks++;
    if (pout_m !== 4'h6 || pv_m !== 1'b1 || pout_l !== 4'h6 || ov_m !== 1'b0) begin
      errors++; $display("FAIL reset_mid_recover: got pout=%h pout_l=%h v=%b ov=%b want 6 6 1 0", pout_m, pout_l, pv_m, ov_m);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
      checks++;
      if (pout_m !== m_pout || pout_l !== m_pout_l || pv_m !== m_valid || pv_l !== m_valid ||
          busy_m !== (q.size() > 0) || busy_l !== (q.size() > 0) ||
          ov_m !== m_over || ov_l !== m_over || fe_m !== m_ferr || fe_l !== m_ferr) begin
        errors++;
        $display("FAIL random cycle %0d: got pout=%h/%h v=%b/%b busy=%b/%b ov=%b/%b fe=%b/%b want pout=%h/%h v=%b busy=%b ov=%b fe=%b",
                 n, pout_m, pout_l, pv_m, pv_l, busy_m, busy_l, ov_m, ov_l, fe_m, fe_l,
                 m_pout, m_pout_l, m_valid, (q.size() > 0), m_over, m_ferr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_gaps();
    test_back_to_back();
    test_simul_pop();
    test_frame_err();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
